// File: rtl/puf_race_sequencer_if.sv
// Request, race-arbiter and response signals of one arbiter-PUF race sequencer.
// The master modport is the sequencer side; slave is the requester/arbiter side.
interface puf_race_sequencer_if #(
  parameter int unsigned CW = 64,
  parameter int unsigned RW = 32
);
  logic          start;
  logic [CW-1:0] seed;
  logic [CW-1:0] challenge;
  logic          arb_rst;
  logic          launch;
  logic          arb_done;
  logic          arb_out;
  logic [RW-1:0] resp;
  logic          resp_valid;
  logic          resp_ready;
  logic          busy;
  logic          timeout_err;

  modport master (
    input  start, seed, arb_done, arb_out, resp_ready,
    output challenge, arb_rst, launch, resp, resp_valid, busy, timeout_err
  );

  modport slave (
    output start, seed, arb_done, arb_out, resp_ready,
    input  challenge, arb_rst, launch, resp, resp_valid, busy, timeout_err
  );
endinterface

// File: rtl/puf_race_sequencer.sv
// Runs RW arbiter-PUF races on LFSR challenges and packs the decisions into one word.
// Define MAJORITY_VOTE_EN to race each challenge three times and keep the majority.
module puf_race_sequencer #(
  parameter int unsigned CW      = 64,
  parameter int unsigned RW      = 32,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                 clk,
  input logic                 rst,
  puf_race_sequencer_if.master bus
);

  localparam int unsigned CntMax = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned BitW   = $clog2(RW);

  typedef enum logic [2:0] {StIdle, StLoad, StLaunch, StWait, StNext, StOut} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   challenge_q, challenge_d;
  logic [RW-1:0]   resp_q, resp_d;
  logic            resp_valid_q, resp_valid_d;
  logic            busy_q, busy_d;
  logic            terr_q, terr_d;
  logic            arb_rst_q, arb_rst_d;
  logic            launch_q, launch_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic            bit_q, bit_d;
  logic            decided;
  logic            decision;
  logic            fb;
`ifdef MAJORITY_VOTE_EN
  logic [1:0]      vote_q, vote_d;
  logic [1:0]      ones_q, ones_d;
`endif

  assign fb = challenge_q[CW-1] ^ challenge_q[CW-2] ^ challenge_q[CW-4] ^ challenge_q[CW-5];

  always_comb begin
    state_d      = state_q;
    challenge_d  = challenge_q;
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q;
    busy_d       = busy_q;
    terr_d       = terr_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    bit_d        = bit_q;
    decided      = 1'b0;
    decision     = 1'b0;
`ifdef MAJORITY_VOTE_EN
    vote_d       = vote_q;
    ones_d       = ones_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          // An all-zero seed would lock the LFSR at zero.
          challenge_d = (bus.seed == '0) ? '1 : bus.seed;
          resp_d      = '0;
          busy_d      = 1'b1;
          terr_d      = 1'b0;
          bit_cnt_d   = '0;
          cnt_d       = CntW'(1);
          state_d     = StLoad;
`ifdef MAJORITY_VOTE_EN
          vote_d      = '0;
          ones_d      = '0;
`endif
        end
      end
      StLoad: begin
        if (cnt_q == CntW'(SETTLE)) begin
          state_d = StLaunch;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLaunch: begin
        state_d = StWait;
        cnt_d   = CntW'(1);
      end
      StWait: begin
        if (bus.arb_done) begin
          decided  = 1'b1;
          decision = bus.arb_out;
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          decided = 1'b1;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
        if (decided) begin
`ifdef MAJORITY_VOTE_EN
          ones_d = ones_q + {1'b0, decision};
          if (vote_q == 2'd2) begin
            bit_d   = (ones_d >= 2'd2);
            state_d = StNext;
          end else begin
            vote_d  = vote_q + 2'd1;
            cnt_d   = CntW'(1);
            state_d = StLoad;
          end
`else
          bit_d   = decision;
          state_d = StNext;
`endif
        end
      end
      StNext: begin
        resp_d      = {resp_q[RW-2:0], bit_q};
        challenge_d = {challenge_q[CW-2:0], fb};
`ifdef MAJORITY_VOTE_EN
        vote_d      = '0;
        ones_d      = '0;
`endif
        if (bit_cnt_q == BitW'(RW - 1)) begin
          resp_valid_d = 1'b1;
          state_d      = StOut;
        end else begin
          bit_cnt_d = bit_cnt_q + BitW'(1);
          cnt_d     = CntW'(1);
          state_d   = StLoad;
        end
      end
      StOut: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          busy_d       = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Outputs are registered from the next state so they line up with it.
    arb_rst_d = !((state_d == StLaunch) || (state_d == StWait));
    launch_d  = (state_d == StLaunch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      challenge_q  <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      terr_q       <= 1'b0;
      arb_rst_q    <= 1'b1;
      launch_q     <= 1'b0;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      bit_q        <= 1'b0;
`ifdef MAJORITY_VOTE_EN
      vote_q       <= '0;
      ones_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      challenge_q  <= challenge_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      terr_q       <= terr_d;
      arb_rst_q    <= arb_rst_d;
      launch_q     <= launch_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_q        <= bit_d;
`ifdef MAJORITY_VOTE_EN
      vote_q       <= vote_d;
      ones_q       <= ones_d;
`endif
    end
  end

  assign bus.challenge   = challenge_q;
  assign bus.arb_rst     = arb_rst_q;
  assign bus.launch      = launch_q;
  assign bus.resp        = resp_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_puf_race_sequencer.sv
// Bench for puf_race_sequencer: behavioural race-arbiter model plus a response scoreboard.
module tb_puf_race_sequencer;

  localparam int unsigned CW      = 64;
  localparam int unsigned RW      = 8;
  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 16;
`ifdef MAJORITY_VOTE_EN
  localparam int Votes  = 3;
  localparam int LatExp = RW * (3 * (SETTLE + 1 + 3) + 1);
`else
  localparam int Votes  = 1;
  localparam int LatExp = RW * (SETTLE + 1 + 3 + 1);
`endif

  typedef struct {
    logic [RW-1:0] resp;
    logic          terr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  puf_race_sequencer_if #(.CW(CW), .RW(RW)) bus ();

  puf_race_sequencer #(
    .CW     (CW),
    .RW     (RW),
    .SETTLE (SETTLE),
    .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t sb_q[$];

  // Arbiter model: 0 = done after delay with out=1, 1 = out=challenge[0],
  // 2 = never done, 3 = votes 1,0,1 per challenge.
  int   mode       = 0;
  int   delay      = 3;
  int   k          = 0;
  logic counting   = 1'b0;
  int   launch_cnt = 0;
  int   vote_base  = 0;

  always @(negedge clk) begin
    if (bus.launch) begin
      k        = 0;
      counting = 1'b1;
      launch_cnt++;
    end else if (counting) begin
      k++;
    end
    bus.arb_done = (mode != 2) && counting && (k == delay);
    case (mode)
      1:       bus.arb_out = bus.challenge[0];
      3:       bus.arb_out = (((launch_cnt - vote_base - 1) % 3) != 1);
      default: bus.arb_out = 1'b1;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] lfsr_next(input logic [CW-1:0] c);
    return {c[CW-2:0], c[CW-1] ^ c[CW-2] ^ c[CW-4] ^ c[CW-5]};
  endfunction

  task automatic push(input logic [RW-1:0] r, input logic t);
    exp_t e;
    e.resp = r;
    e.terr = t;
    sb_q.push_back(e);
  endtask

  task automatic do_start(input logic [CW-1:0] s);
    bus.seed  = s;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_launch();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.launch && t < 200);
    if (!bus.launch) check("launch_wait", 64'd0, 64'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.resp_valid && lat < 4000) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.resp_valid) check("resp_valid_wait", 64'd0, 64'd1);
  endtask

  task automatic finish_word();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      if (bus.resp_valid) begin
        check("resp", bus.resp, e.resp);
        check("timeout_err", bus.timeout_err, e.terr);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("resp_valid_clr", bus.resp_valid, 0);
        check("busy_clr", bus.busy, 0);
      end
    end
  endtask

  initial begin
    int            lat;
    int            w;
    int            seen;
    logic [CW-1:0] c;
    logic [RW-1:0] r;

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.seed       = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_arb_rst", bus.arb_rst, 1);
    check("rst_launch", bus.launch, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_challenge", bus.challenge, 0);
    check("rst_resp", bus.resp, 0);
    check("rst_terr", bus.timeout_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Constant-1 arbiter: all-ones word with fixed latency.
    mode = 0; delay = 3; vote_base = launch_cnt;
    push(8'hFF, 1'b0);
    do_start(64'h1);
    check("busy_set", bus.busy, 1);
    wait_valid(lat);
    check("latency", lat, LatExp);
    check("launch_count", launch_cnt - vote_base, RW * Votes);
    finish_word();

    // out = challenge[0]: check the LFSR sequence at every launch.
    mode = 1;
    c = 64'h1; r = '0;
    for (int i = 0; i < RW; i++) begin
      r = {r[RW-2:0], c[0]};
      c = lfsr_next(c);
    end
    push(r, 1'b0);
    do_start(64'h1);
    c = 64'h1;
    for (int i = 0; i < RW; i++) begin
      for (int v = 0; v < Votes; v++) begin
        wait_launch();
        check("challenge_seq", bus.challenge, c);
      end
      c = lfsr_next(c);
    end
    wait_valid(lat);
    finish_word();

    // No done ever: every race times out after exactly TIMEOUT wait cycles.
    mode = 2;
    push(8'h00, 1'b1);
    do_start(64'h5A5A);
    wait_launch();
    w = 0;
    @(negedge clk);
    while (!bus.arb_rst && w < 100) begin
      w++;
      @(negedge clk);
    end
    check("wait_len", w, TIMEOUT);
    wait_valid(lat);
    finish_word();

    // Backpressure: OUT holds steady and ignores start.
    mode = 0; delay = 3;
    push(8'hFF, 1'b0);
    do_start(64'hDEAD_BEEF_0123_4567);
    check("terr_clr_on_start", bus.timeout_err, 0);
    c = 64'hDEAD_BEEF_0123_4567;
    for (int i = 0; i < RW; i++) c = lfsr_next(c);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      bus.seed  = 64'h77;
      bus.start = (i == 3);
      @(negedge clk);
      check("hold_valid", bus.resp_valid, 1);
      check("hold_busy", bus.busy, 1);
      check("hold_resp", bus.resp, 8'hFF);
      check("hold_chal", bus.challenge, c);
    end
    bus.start = 1'b0;
    finish_word();
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_resp_hold", bus.resp, 8'hFF);
    check("idle_arb_rst", bus.arb_rst, 1);

    // Done on the last permitted wait cycle beats the timeout.
    mode = 0; delay = TIMEOUT;
    push(8'hFF, 1'b0);
    do_start(64'h3);
    wait_valid(lat);
    finish_word();

`ifdef MAJORITY_VOTE_EN
    // Votes 1,0,1 resolve to 1 on every challenge.
    mode = 3; delay = 3; vote_base = launch_cnt;
    push(8'hFF, 1'b0);
    do_start(64'h1);
    wait_valid(lat);
    check("vote_launches", launch_cnt - vote_base, RW * 3);
    finish_word();
`endif

    // Zero seed maps to all-ones; reset mid-WAIT abandons the word.
    mode = 2; delay = 3;
    do_start(64'h0);
    wait_launch();
    check("zero_seed_chal", bus.challenge, {CW{1'b1}});
    @(negedge clk);
    check("in_wait_arb_rst", bus.arb_rst, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_arb_rst", bus.arb_rst, 1);
    check("mid_rst_launch", bus.launch, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_challenge", bus.challenge, 0);
    check("mid_rst_resp", bus.resp, 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    check("no_valid_after_rst", seen, 0);
    check("busy_after_rst", bus.busy, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
